// File: rtl/via_port_arbiter_pkg.sv
// Shared constants and packet header helpers for the via port arbiter and sink-side checkers.
// Header layout, MSB first: src | dst | id | payload.
package via_pkg;

  localparam int ID_WIDTH = 8;

  function automatic int src_msb(input int width);
    return width - 1;
  endfunction

  function automatic int dst_msb(input int width, input int n_addr_width);
    return width - 1 - n_addr_width;
  endfunction

  function automatic int id_msb(input int width, input int n_addr_width);
    return width - 1 - 2 * n_addr_width;
  endfunction

  function automatic int payload_msb(input int width, input int n_addr_width);
    return width - 1 - 2 * n_addr_width - ID_WIDTH;
  endfunction

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/via_port_arbiter_if.sv
// Source-side request bus and router-side output bus of the via port arbiter.
// master = sources and router, slave = arbiter.
interface via_port_arbiter_if #(
  parameter int NUM_SRC      = 4,
  parameter int WIDTH        = 32,
  parameter int N_ADDR_WIDTH = 4
) ();

  logic [NUM_SRC*WIDTH-1:0]        req_data_in;
  logic [NUM_SRC*N_ADDR_WIDTH-1:0] req_dest_in;
  logic [NUM_SRC-1:0]              req_valid_in;
  logic [NUM_SRC-1:0]              req_ready_out;
  logic [WIDTH-1:0]                data_out;
  logic [N_ADDR_WIDTH-1:0]         dest_out;
  logic                            valid_out;
  logic                            ready_in;
  logic [NUM_SRC-1:0]              grant_out;

  modport master (
    output req_data_in, req_dest_in, req_valid_in, ready_in,
    input  req_ready_out, data_out, dest_out, valid_out, grant_out
  );

  modport slave (
    input  req_data_in, req_dest_in, req_valid_in, ready_in,
    output req_ready_out, data_out, dest_out, valid_out, grant_out
  );

endinterface

// File: rtl/via_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain priority search.
module rr_arbiter
  import via_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IDX_W  = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [2*NUM_SRC-1:0] req_masked;
  logic                 found;

  always_comb begin
    req_dbl    = {req, req};
    req_masked = '0;
    for (int j = 0; j < 2 * NUM_SRC; j++) begin
      req_masked[j] = req_dbl[j] && (j >= int'(ptr));
    end
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < 2 * NUM_SRC; j++) begin
      if (req_masked[j] && !found) begin
        found   = 1'b1;
        gnt_idx = (j >= NUM_SRC) ? IDX_W'(j - NUM_SRC) : IDX_W'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/via_port_arbiter.sv
// Round-robin share of one NoC injection port among NUM_SRC sources, with a
// one-entry output register, a saturating drain counter and a sticky done flag.
module via_port_arbiter
  import via_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int CNT_WIDTH    = 16,
  parameter int DONE_COUNT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              done,
  via_port_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SRC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [N_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    done_q, done_d;

  logic                    load_en;
  logic                    arb_en;
  logic                    accept;
  logic                    drain;
  logic [NUM_SRC-1:0]      gnt;
  logic [IDX_W-1:0]        win_idx;
  logic [WIDTH-1:0]        win_data;
  logic [N_ADDR_WIDTH-1:0] win_dest;

  // Gating with rst keeps every source un-acked while a held packet is being dropped.
  assign load_en = !valid_q || bus.ready_in;
  assign arb_en  = load_en && !rst;
  assign accept  = arb_en && (|bus.req_valid_in);
  assign drain   = valid_q && bus.ready_in;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req     (bus.req_valid_in),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (win_idx)
  );

  always_comb begin
    win_data = '0;
    win_dest = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = bus.req_data_in[i*WIDTH +: WIDTH];
        win_dest = bus.req_dest_in[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = win_data;
      dest_d  = win_dest;
      grant_d = gnt;
      ptr_d   = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
      grant_d = '0;
    end
    if (drain && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    done_d = done_q || (32'(cnt_d) >= DONE_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready_out = gnt;
  assign bus.data_out      = data_q;
  assign bus.dest_out      = dest_q;
  assign bus.valid_out     = valid_q;
  assign bus.grant_out     = grant_q;
  assign done              = done_q;

endmodule

// File: tb/tb_via_port_arbiter.sv
// Bench for via_port_arbiter: vector table, corner-case sequences and a
// randomized run checked against a queue-free round-robin reference model.
module tb_via_port_arbiter;

  localparam int NS   = 4;
  localparam int W    = 32;
  localparam int AW   = 4;
  localparam int DONE = 10;

  logic clk = 1'b0;
  logic rst;
  logic done;

  via_port_arbiter_if #(.NUM_SRC(NS), .WIDTH(W), .N_ADDR_WIDTH(AW)) bus ();

  via_port_arbiter #(
    .NUM_SRC(NS), .WIDTH(W), .N(16), .N_ADDR_WIDTH(AW), .CNT_WIDTH(16), .DONE_COUNT(DONE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  src_data [NS];
  logic [AW-1:0] src_dest [NS];

  // reference model state
  bit            m_valid;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_dest;
  int            m_grant;
  int            m_ptr;
  int            m_cnt;
  bit            m_done;
  int            wait_n [NS];
  logic [NS-1:0] obs_rdy;
  logic [NS-1:0] last_acc;

  typedef struct {
    logic [NS-1:0] vld;
    logic          rdy;
    logic [NS-1:0] exp_rdy;
    logic          exp_valid;
    logic [NS-1:0] exp_grant;
    int            exp_src;
    logic          exp_done;
  } vec_t;

  vec_t tbl [16];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input logic [NS-1:0] vld, input logic rdy, input logic r);
    int            win;
    int            idx;
    bit            load;
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] exp_grant;
    @(negedge clk);
    rst              = r;
    bus.req_valid_in = vld;
    bus.ready_in     = rdy;
    for (int i = 0; i < NS; i++) begin
      bus.req_data_in[i*W +: W]   = src_data[i];
      bus.req_dest_in[i*AW +: AW] = src_dest[i];
    end
    #1;
    win  = -1;
    load = !m_valid || rdy;
    if (!r && load) begin
      for (int k = 0; k < NS; k++) begin
        idx = (m_ptr + k) % NS;
        if (vld[idx] && win < 0) win = idx;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    obs_rdy  = bus.req_ready_out;
    last_acc = obs_rdy;
    chk("req_ready_out", obs_rdy, exp_rdy);

    for (int i = 0; i < NS; i++) begin
      if (r || !vld[i] || obs_rdy[i]) begin
        wait_n[i] = 0;
      end else if (obs_rdy != '0) begin
        wait_n[i]++;
        chk("fairness_starved", wait_n[i] > NS - 1, 0);
      end
    end

    if (r) begin
      m_valid = 0; m_data = '0; m_dest = '0; m_grant = -1;
      m_ptr = 0; m_cnt = 0; m_done = 0;
    end else begin
      if (m_valid && rdy) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt >= DONE) m_done = 1;
      end
      if (win >= 0) begin
        m_valid = 1; m_data = src_data[win]; m_dest = src_dest[win];
        m_grant = win; m_ptr = (win + 1) % NS;
      end else if (m_valid && rdy) begin
        m_valid = 0; m_grant = -1;
      end
    end

    @(posedge clk);
    #1;
    exp_grant = '0;
    if (m_grant >= 0) exp_grant[m_grant] = 1'b1;
    chk("valid_out", bus.valid_out, m_valid);
    chk("data_out", bus.data_out, m_data);
    chk("dest_out", bus.dest_out, m_dest);
    chk("grant_out", bus.grant_out, exp_grant);
    chk("done", done, m_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] v;

    rst = 1'b1;
    bus.req_data_in  = '0;
    bus.req_dest_in  = '0;
    bus.req_valid_in = '0;
    bus.ready_in     = 1'b0;
    m_valid = 0; m_data = '0; m_dest = '0; m_grant = -1;
    m_ptr = 0; m_cnt = 0; m_done = 0;
    for (int i = 0; i < NS; i++) begin
      wait_n[i]   = 0;
      src_data[i] = 32'hC0DE_0000 | 32'(i);
      src_dest[i] = AW'(3 * i + 1);
    end

    // reset: everything zero, no ready even with all sources requesting
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b1111, 1'b1, 1'b1);
    chk("rst_ready", obs_rdy, 4'b0000);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_grant", bus.grant_out, 4'b0000);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_done", done, 1'b0);

    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 2, 1'b0};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 2, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 3, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 0, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2, 1'b0};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0100, 2, 1'b0};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0100, 2, 1'b0};
    tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 3, 1'b0};
    tbl[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001, 0, 1'b0};
    tbl[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 3, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 3, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 3, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 1, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1, 1'b1};
    tbl[15] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1, 1'b1};

    for (int t = 0; t < 16; t++) begin
      tick(tbl[t].vld, tbl[t].rdy, 1'b0);
      chk("tbl_ready", obs_rdy, tbl[t].exp_rdy);
      chk("tbl_valid", bus.valid_out, tbl[t].exp_valid);
      chk("tbl_grant", bus.grant_out, tbl[t].exp_grant);
      chk("tbl_data", bus.data_out, src_data[tbl[t].exp_src]);
      chk("tbl_dest", bus.dest_out, src_dest[tbl[t].exp_src]);
      chk("tbl_done", done, tbl[t].exp_done);
    end

    // backpressure: 5 stalled cycles hold src1's packet, then src2 (ptr=2) wins at once
    for (int s = 0; s < 5; s++) begin
      tick(4'b1111, 1'b0, 1'b0);
      chk("stall_ready", obs_rdy, 4'b0000);
      chk("stall_data", bus.data_out, src_data[1]);
      chk("stall_grant", bus.grant_out, 4'b0010);
    end
    tick(4'b1111, 1'b1, 1'b0);
    chk("release_ready", obs_rdy, 4'b0100);
    chk("release_grant", bus.grant_out, 4'b0100);
    chk("release_data", bus.data_out, src_data[2]);

    // reset during a stall drops the packet, clears done and the pointer
    tick(4'b1111, 1'b0, 1'b0);
    tick(4'b1111, 1'b0, 1'b1);
    chk("midrst_ready", obs_rdy, 4'b0000);
    chk("midrst_valid", bus.valid_out, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_grant", bus.grant_out, 4'b0000);
    tick(4'b1111, 1'b1, 1'b0);
    chk("midrst_ptr0", obs_rdy, 4'b0001);

    // done rises on the edge of the 10th drain and stays
    tick(4'b0000, 1'b0, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      tick((c <= 12) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      chk("done_stream", done, c >= 11);
    end

    // randomized traffic, sources hold valid until accepted (occasionally withdrawing)
    tick(4'b0000, 1'b0, 1'b1);
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!v[i]) v[i] = ($urandom_range(2) == 0);
        else if ($urandom_range(19) == 0) v[i] = 1'b0;
        src_data[i] = $urandom;
        src_dest[i] = AW'($urandom);
      end
      tick(v, $urandom_range(3) != 0, 1'b0);
      v = v & ~last_acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
